// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES slices, one slice per stage, valid/ready with full stall.
// Define PIPE_ADDER_SUB_EN to add the `sub` port (x - y - c_in when sub=1).
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int SLICE       = WIDTH / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_params
    $error("pipe_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic             stall;
  logic [WIDTH-1:0] y_eff;
  logic             c_eff;
  logic             ovf_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

`ifdef PIPE_ADDER_SUB_EN
  assign y_eff = sub ? ~y : y;
  assign c_eff = sub ? ~c_in : c_in;
`else
  assign y_eff = y;
  assign c_eff = c_in;
`endif

  // Stage k adds slice k; it carries forward the finished low result bits (DONE)
  // and only the operand bits not yet consumed (REM), so nothing dead is registered.
  for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SLICE;
    localparam int REM  = WIDTH - DONE;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic             carry_in;
    logic             valid_in;
    logic [SLICE:0]   slice_sum;
    logic [DONE-1:0]  s_d;
    logic [DONE-1:0]  s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign op_a     = x[SLICE-1:0];
      assign op_b     = y_eff[SLICE-1:0];
      assign carry_in = c_eff;
      assign valid_in = in_valid;
      assign s_d      = slice_sum[SLICE-1:0];
    end else begin : g_body
      assign op_a     = g_stage[k-1].g_pass.a_q[SLICE-1:0];
      assign op_b     = g_stage[k-1].g_pass.b_q[SLICE-1:0];
      assign carry_in = g_stage[k-1].c_q;
      assign valid_in = g_stage[k-1].v_q;
      assign s_d      = {slice_sum[SLICE-1:0], g_stage[k-1].s_q};
    end

    assign slice_sum = {1'b0, op_a} + {1'b0, op_b} + {{SLICE{1'b0}}, carry_in};

    // NOTE: registers use non-blocking assignments so every stage samples the
    // previous stage's old value on the same edge; blocking here would collapse the pipe.
    // NOTE: datapath registers are reset as well, so sum/c_out read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= valid_in;
        // Bubbles leave the data registers untouched.
        if (valid_in) begin
          c_q <= slice_sum[SLICE];
          s_q <= s_d;
        end
      end
    end

    if (REM > 0) begin : g_pass
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = x[WIDTH-1:SLICE];
        assign b_d = y_eff[WIDTH-1:SLICE];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_pass.a_q[SLICE +: REM];
        assign b_d = g_stage[k-1].g_pass.b_q[SLICE +: REM];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && valid_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  // Signed overflow: both operand MSBs agree but the result MSB differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall && g_stage[LAST].valid_in) begin
      ovf_q <= (g_stage[LAST].op_a[SLICE-1] == g_stage[LAST].op_b[SLICE-1]) &
               (g_stage[LAST].slice_sum[SLICE-1] != g_stage[LAST].op_a[SLICE-1]);
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign c_out     = g_stage[LAST].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: STAGES=4 under test plus STAGES=1 and STAGES=16 instances
// sharing the same input stream, all scored against an arithmetic reference model.
module tb_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, c_out, ovf;
  logic [W-1:0] sum;
  logic         in_ready_s1, out_valid_s1, c_out_s1, ovf_s1;
  logic [W-1:0] sum_s1;
  logic         in_ready_s16, out_valid_s16, c_out_s16, ovf_s16;
  logic [W-1:0] sum_s16;

  int n_vec = 0;
  int n_err = 0;
  int n_push [3];
  int n_taken [3];
  logic [17:0] q [3][$];

  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;

  pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
    .x(x), .y(y), .c_in(c_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_s1), .out_ready(1'b1), .sum(sum_s1), .c_out(c_out_s1), .ovf(ovf_s1)
  );

  pipe_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s16),
    .x(x), .y(y), .c_in(c_in),
`ifdef PIPE_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid_s16), .out_ready(1'b1), .sum(sum_s16), .c_out(c_out_s16), .ovf(ovf_s16)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the effective operands.
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input logic s);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   r;
    logic         ov;
    be = s ? ~b : b;
    ce = s ? ~c : c;
    r  = {1'b0, a} + {1'b0, be} + (W+1)'(ce);
    ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r[W], r[W-1:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic sb(input int i, input logic o_valid, input logic o_ready,
                    input logic i_ready, input logic [17:0] got);
    logic [17:0] e;
    check($sformatf("in_ready[%0d]", i), 32'(i_ready), 32'(!(o_valid && !o_ready)));
    if (o_valid && o_ready) begin
      n_taken[i]++;
      if (q[i].size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected[%0d]: got 0x%0h, expected no output", i, got);
      end else begin
        e = q[i].pop_front();
        check($sformatf("result[%0d]", i), 32'(got), 32'(e));
      end
    end
    if (in_valid && i_ready) begin
      n_push[i]++;
      q[i].push_back(model(x, y, c_in, sub));
    end
  endtask

  // Compare process: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_during_stall", 32'({out_valid, ovf, c_out, sum}), 32'({1'b1, prev_out}));
      sb(0, out_valid, out_ready, in_ready, {ovf, c_out, sum});
      sb(1, out_valid_s1, 1'b1, in_ready_s1, {ovf_s1, c_out_s1, sum_s1});
      sb(2, out_valid_s16, 1'b1, in_ready_s16, {ovf_s16, c_out_s16, sum_s16});
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, c_out, sum};
    end
  end

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One isolated transaction; measures latency on all three instances.
  task automatic single(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic [17:0] exp);
    int lat [3];
    logic [17:0] got;
    lat = '{0, 0, 0};
    got = '0;
    idle(20);
    x = a; y = b; c_in = c; sub = s; in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid && lat[0] == 0) begin
        lat[0] = k;
        got = {ovf, c_out, sum};
      end
      if (out_valid_s1 && lat[1] == 0) lat[1] = k;
      if (out_valid_s16 && lat[2] == 0) lat[2] = k;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    check({nm, "_value"}, 32'(got), 32'(exp));
    check({nm, "_latency4"}, 32'(lat[0]), 32'd4);
    check({nm, "_latency1"}, 32'(lat[1]), 32'd1);
    check({nm, "_latency16"}, 32'(lat[2]), 32'd16);
  endtask

  // Random stream; holds the offered item until accepted. Forced stall window optional.
  task automatic stream(input int n, input int vld_pct, input int rdy_pct,
                        input int stall_from, input int stall_len);
    logic acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (stall_len > 2 && i == stall_from + 2)
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        x    = W'($urandom);
        y    = W'($urandom);
        c_in = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
        sub  = 1'($urandom);
`else
        sub  = 1'b0;
`endif
        in_valid = ($urandom_range(99) < vld_pct);
      end
      if (i >= stall_from && i < stall_from + stall_len) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0, t0;
    for (int i = 0; i < 3; i++) begin
      n_push[i]  = 0;
      n_taken[i] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'({ovf, c_out, sum}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_aux_valid", 32'({out_valid_s1, out_valid_s16}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    single("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    single("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    single("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
    single("plain_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556);
`ifdef PIPE_ADDER_SUB_EN
    single("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    single("sub_no_borrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 18'h10002);
`endif

    // 100 back-to-back operands at full throughput.
    idle(20);
    p0 = n_push[0];
    t0 = n_taken[0];
    stream(100, 100, 100, -1, 0);
    idle(20);
    check("b2b_accepted", 32'(n_push[0] - p0), 32'd100);
    check("b2b_delivered", 32'(n_taken[0] - t0), 32'd100);

    // Full pipe held off for 5 cycles, then random mixes of bubbles and backpressure.
    stream(30, 100, 100, 10, 5);
    stream(150, 70, 60, -1, 0);
    idle(20);
    check("mix_no_loss", 32'(n_taken[0]), 32'(n_push[0]));

    // Reset with results in flight.
    stream(8, 100, 100, -1, 0);
    #1;
    check("pre_reset_busy", 32'(out_valid), 32'd1);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'({ovf, c_out, sum}), 32'd0);
    check("midrst_aux_valid", 32'({out_valid_s1, out_valid_s16}), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    single("post_reset", 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 18'h0B4B4);

    stream(60, 90, 80, -1, 0);
    idle(30);
    check("drain_main", 32'(q[0].size()), 32'd0);
    check("drain_s1", 32'(q[1].size()), 32'd0);
    check("drain_s16", 32'(q[2].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
